// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int DEF_CH      = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PRESC_W = 16;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every div+1 clocks; the divide value is latched
// only at period boundaries (or continuously while idle).
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  input  logic               boundary_load,
  output logic               tick
);

  logic [PRESC_W-1:0] pre_q, pre_d;
  logic [PRESC_W-1:0] div_q, div_d;

  assign tick = en && (pre_q == div_q);

  always_comb begin
    pre_d = pre_q + 1'b1;
    div_d = div_q;
    if (!en || tick) pre_d = '0;
    if (!en || boundary_load) div_d = div;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      div_q <= '0;
    end else begin
      pre_q <= pre_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel
// double-buffered duty compare applied only at period boundaries.
//   dir      | meaning
//   DIR_UP   | counting 0 -> P (edge mode always stays here)
//   DIR_DOWN | center mode, counting P-1 -> 0
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter  int CH      = DEF_CH,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int PRESC_W = DEF_PRESC_W,
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               center,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   period,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_ch,
  input  logic [WIDTH-1:0]   duty_val,
  output logic [CH-1:0]      pwm_out,
  output logic               period_tick,
  output logic [WIDTH-1:0]   cnt_out
);

  logic             tick;
  logic             boundary;
  logic             load;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             dir_q, dir_d;
  pwm_mode_e        mode_q, mode_d;
  logic             ptick_q, ptick_d;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .div           (presc),
    .boundary_load (boundary),
    .tick          (tick)
  );

  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    boundary = 1'b0;
    if (!en) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      per_d  = period;
      mode_d = center ? PWM_CENTER : PWM_EDGE;
    end else if (tick) begin
      if (per_q == '0) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else if (mode_q == PWM_EDGE) begin
        if (cnt_q == per_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dir_q == DIR_UP && cnt_q != per_q) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // turning at the top or already descending; reaching 0 closes the period
        cnt_d    = cnt_q - 1'b1;
        dir_d    = DIR_DOWN;
        boundary = (cnt_q == WIDTH'(1));
      end
      if (boundary) begin
        dir_d  = DIR_UP;
        per_d  = period;
        mode_d = center ? PWM_CENTER : PWM_EDGE;
      end
    end
    ptick_d = boundary;
    load    = boundary || !en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      per_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= PWM_EDGE;
      ptick_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      ptick_q <= ptick_d;
    end
  end

  assign cnt_out     = cnt_q;
  assign period_tick = ptick_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic             pwm_q, pwm_d;

    // active takes the pre-write shadow, so a write on the boundary waits a period
    always_comb begin
      shadow_d = shadow_q;
      if (duty_wr && duty_ch == CH_W'(i)) shadow_d = duty_val;
      act_d = load ? shadow_q : act_q;
      pwm_d = en && (cnt_q < act_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        act_q    <= '0;
        pwm_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        act_q    <= act_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: phase-based reference model feeding a
// scoreboard checked every cycle, plus directed period/duty measurements.
module tb_pwm_multi_gen;

  localparam int CH      = 4;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 16;
  localparam int EW      = CH + 1 + WIDTH;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               center = 1'b0;
  logic [PRESC_W-1:0] presc = '0;
  logic [WIDTH-1:0]   period = '0;
  logic               duty_wr = 1'b0;
  logic [1:0]         duty_ch = '0;
  logic [WIDTH-1:0]   duty_val = '0;
  logic [CH-1:0]      pwm_out;
  logic               period_tick;
  logic [WIDTH-1:0]   cnt_out;

  pwm_multi_gen #(.CH(CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .center      (center),
    .presc       (presc),
    .period      (period),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .duty_val    (duty_val),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .cnt_out     (cnt_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: position within the period as a phase index
  int m_pre = 0, m_div = 0, m_p = 0, m_phase = 0;
  bit m_ctr = 0;
  int m_sh[CH] = '{default: 0};
  int m_act[CH] = '{default: 0};
  logic [EW-1:0] sb[$];
  logic [CH-1:0] m_npwm;
  bit m_bnd;
  int m_cur;

  function automatic int cnt_of(int ph, int p, bit ctr);
    if (ctr && ph > p) return 2 * p - ph;
    return ph;
  endfunction

  function automatic int plen(int p, bit ctr);
    if (p == 0) return 1;
    return ctr ? 2 * p : p + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_div = 0; m_p = 0; m_phase = 0; m_ctr = 0;
      for (int i = 0; i < CH; i++) begin
        m_sh[i] = 0;
        m_act[i] = 0;
      end
    end else begin
      m_cur = cnt_of(m_phase, m_p, m_ctr);
      for (int i = 0; i < CH; i++) m_npwm[i] = en && (m_cur < m_act[i]);
      m_bnd = 0;
      if (!en) begin
        m_pre = 0; m_phase = 0;
        m_act = m_sh; m_p = int'(period); m_div = int'(presc); m_ctr = center;
      end else begin
        if (m_pre == m_div) begin
          m_pre = 0;
          m_phase++;
          if (m_phase >= plen(m_p, m_ctr)) begin
            m_phase = 0;
            m_bnd = 1;
          end
        end else begin
          m_pre++;
        end
        if (m_bnd) begin
          m_act = m_sh; m_p = int'(period); m_div = int'(presc); m_ctr = center;
        end
      end
      if (duty_wr && int'(duty_ch) < CH) m_sh[duty_ch] = int'(duty_val);
      sb.push_back({m_npwm, m_bnd, WIDTH'(cnt_of(m_phase, m_p, m_ctr))});
    end
  end

  logic [EW-1:0] exp_e;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_e = sb.pop_front();
      check_eq("sb_pwm", 32'(pwm_out), 32'(exp_e[EW-1 -: CH]));
      check_eq("sb_tick", 32'(period_tick), 32'(exp_e[WIDTH]));
      check_eq("sb_cnt", 32'(cnt_out), 32'(exp_e[WIDTH-1:0]));
    end
  end

  int hi_cnt[CH];

  task automatic wr_duty(input int ch, input int v);
    @(negedge clk);
    duty_wr = 1'b1; duty_ch = 2'(ch); duty_val = WIDTH'(v);
    @(negedge clk);
    duty_wr = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (period_tick) return;
    end
    check_eq("tick_timeout", 0, 1);
  endtask

  task automatic count_high(input int n);
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
    end
  endtask

  task automatic measure_period(input string tag, input int exp);
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (period_tick) begin
        check_eq(tag, k, exp);
        return;
      end
    end
    check_eq({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    check_eq("rst_pwm", 32'(pwm_out), 0);
    check_eq("rst_tick", 32'(period_tick), 0);
    check_eq("rst_cnt", 32'(cnt_out), 0);
    rst_n = 1'b1;

    // edge mode, P=9, duties 0/3/9/10
    period = 8'd9;
    wr_duty(0, 0); wr_duty(1, 3); wr_duty(2, 9); wr_duty(3, 10);
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_tick(100);
    count_high(10);
    check_eq("t1_ch0", hi_cnt[0], 0);
    check_eq("t1_ch1", hi_cnt[1], 3);
    check_eq("t1_ch2", hi_cnt[2], 9);
    check_eq("t1_ch3", hi_cnt[3], 10);
    check_eq("t1_tick", 32'(period_tick), 1);

    // mid-period shadow write keeps the running period intact
    hi_cnt[1] = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      hi_cnt[1] += int'(pwm_out[1]);
      if (k == 3) begin
        duty_wr = 1'b1; duty_ch = 2'd1; duty_val = 8'd7;
      end else begin
        duty_wr = 1'b0;
      end
    end
    check_eq("t3_old", hi_cnt[1], 3);
    check_eq("t3_tick", 32'(period_tick), 1);
    count_high(10);
    check_eq("t3_new", hi_cnt[1], 7);

    // write during the boundary cycle (cnt at P)
    begin : t5_wait
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (cnt_out == 8'd9) disable t5_wait;
      end
      check_eq("t5_timeout", 0, 1);
    end
    duty_wr = 1'b1; duty_ch = 2'd2; duty_val = 8'd5;
    @(negedge clk);
    duty_wr = 1'b0;
    check_eq("t5_tick", 32'(period_tick), 1);
    count_high(10);
    check_eq("t5_old", hi_cnt[2], 9);
    count_high(10);
    check_eq("t5_new", hi_cnt[2], 5);

    // center mode P=4
    center = 1'b1; period = 8'd4;
    wr_duty(1, 2);
    wait_tick(100);
    wait_tick(100);
    measure_period("t2_period", 8);
    count_high(8);
    check_eq("t2_ch0", hi_cnt[0], 0);
    check_eq("t2_ch3", hi_cnt[3], 8);

    // P=0: every tick is a boundary
    center = 1'b0; period = 8'd0;
    wait_tick(100);
    wait_tick(100);
    measure_period("p0_period", 1);
    check_eq("p0_cnt", 32'(cnt_out), 0);

    // prescaler 2, P=3, edge
    presc = 16'd2; period = 8'd3;
    wait_tick(100);
    wait_tick(100);
    measure_period("t4_period", 12);

    // en drop mid-period, then restart with a full first period
    wait_tick(100);
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_eq("t6_en_cnt", 32'(cnt_out), 0);
    check_eq("t6_en_pwm", 32'(pwm_out), 0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    measure_period("t6_restart", 12);

    // async reset mid-period
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pwm", 32'(pwm_out), 0);
    check_eq("t6_rst_cnt", 32'(cnt_out), 0);
    check_eq("t6_rst_tick", 32'(period_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_duty(0, 2);
    wr_duty(3, 4);
    wait_tick(100);
    wait_tick(100);
    measure_period("t6_rst_period", 12);
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
